// File: rtl/safe_keypad_scanner.sv
// Keypad front end for the safe controller: scans a 4x3 active-low key
// matrix, debounces key presses and the door-seal sensor, and hands one
// 4-bit event per press to the safe FSM over a valid/ready register.
module safe_keypad_scanner #(
  parameter int ROW_SETTLE      = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic [3:0] row_no,
  input  logic [2:0] col_ni,
  input  logic       door_sealed_i,
  output logic       key_valid_o,
  output logic [3:0] key_code_o,
  input  logic       key_ready_i,
  output logic       overrun_o
);

  localparam int SW = $clog2(ROW_SETTLE + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  // Sampling happens once the settle count has covered ROW_SETTLE cycles,
  // which also absorbs the two-cycle column synchroniser after a row change.
  localparam logic [SW-1:0] SETTLE_LAST = SW'(ROW_SETTLE);
  localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] S_SCAN     = 2'd0;
  localparam logic [1:0] S_DEBOUNCE = 2'd1;
  localparam logic [1:0] S_PRESSED  = 2'd2;
  localparam logic [1:0] S_RELEASE  = 2'd3;

  localparam logic [3:0] CODE_DOOR = 4'hC;

  logic [2:0]    col_s1, col_s2;
  logic          door_s1, door_s2;
  logic          door_lvl;
  logic [DW-1:0] door_cnt;
  logic [1:0]    state;
  logic [1:0]    row;
  logic [SW-1:0] settle_cnt;
  logic [DW-1:0] deb_cnt;
  logic [2:0]    lat_col;
  logic [3:0]    lat_code;
  logic          key_ev;
  logic          door_ev;
  logic          any_ev;
  logic          handshake;

  // Exactly one column pulled low on the sampled pattern.
  function automatic logic single_low(input logic [2:0] cols);
    return (cols == 3'b110) || (cols == 3'b101) || (cols == 3'b011);
  endfunction

  // Keypad legend: row/column position to safe key code.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [2:0] cols);
    logic [3:0] code;
    case ({r, cols})
      {2'd0, 3'b110}: code = 4'h1;
      {2'd0, 3'b101}: code = 4'h2;
      {2'd0, 3'b011}: code = 4'h3;
      {2'd1, 3'b110}: code = 4'h4;
      {2'd1, 3'b101}: code = 4'h5;
      {2'd1, 3'b011}: code = 4'h6;
      {2'd2, 3'b110}: code = 4'h7;
      {2'd2, 3'b101}: code = 4'h8;
      {2'd2, 3'b011}: code = 4'h9;
      {2'd3, 3'b110}: code = 4'hA;
      {2'd3, 3'b101}: code = 4'h0;
      {2'd3, 3'b011}: code = 4'hB;
      default:        code = 4'h0;
    endcase
    return code;
  endfunction

  assign row_no = ~(4'b0001 << row);

  // Two-flop synchronisers for the asynchronous column and door inputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_s1  <= 3'b111;
      col_s2  <= 3'b111;
      door_s1 <= 1'b0;
      door_s2 <= 1'b0;
    end else begin
      col_s1  <= col_ni;
      col_s2  <= col_s1;
      door_s1 <= door_sealed_i;
      door_s2 <= door_s1;
    end
  end

  // Door level follows the sensor only after a full run of differing samples.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      door_lvl <= 1'b0;
      door_cnt <= '0;
    end else if (door_s2 != door_lvl) begin
      if (door_cnt == DEB_LAST) begin
        door_lvl <= door_s2;
        door_cnt <= '0;
      end else begin
        door_cnt <= door_cnt + DW'(1);
      end
    end else begin
      door_cnt <= '0;
    end
  end

  // Scan / debounce / release state machine for the key matrix.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= S_SCAN;
      row        <= 2'd0;
      settle_cnt <= '0;
      deb_cnt    <= '0;
      lat_col    <= 3'b111;
      lat_code   <= 4'h0;
    end else begin
      case (state)
        S_SCAN: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            if (single_low(col_s2)) begin
              lat_col  <= col_s2;
              lat_code <= key_map(row, col_s2);
              deb_cnt  <= '0;
              state    <= S_DEBOUNCE;
            end else begin
              row <= row + 2'd1;
            end
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        S_DEBOUNCE: begin
          if (col_s2 != lat_col) begin
            settle_cnt <= '0;
            state      <= S_SCAN;
          end else if (deb_cnt == DEB_LAST) begin
            state <= S_PRESSED;
          end else begin
            deb_cnt <= deb_cnt + DW'(1);
          end
        end
        S_PRESSED: begin
          deb_cnt <= '0;
          state   <= S_RELEASE;
        end
        default: begin
          // Any low column, including a different key, restarts the release run.
          if (col_s2 != 3'b111) begin
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            deb_cnt    <= '0;
            settle_cnt <= '0;
            row        <= row + 2'd1;
            state      <= S_SCAN;
          end else begin
            deb_cnt <= deb_cnt + DW'(1);
          end
        end
      endcase
    end
  end

  assign key_ev    = (state == S_PRESSED);
  assign door_ev   = door_s2 && !door_lvl && (door_cnt == DEB_LAST);
  assign any_ev    = key_ev || door_ev;
  assign handshake = key_valid_o && key_ready_i;

  // Single-entry output register; the door event takes priority over a key.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      key_valid_o <= 1'b0;
      key_code_o  <= 4'h0;
      overrun_o   <= 1'b0;
    end else begin
      overrun_o <= (any_ev && key_valid_o && !handshake) || (key_ev && door_ev);
      if (any_ev && (!key_valid_o || handshake)) begin
        key_code_o  <= door_ev ? CODE_DOOR : lat_code;
        key_valid_o <= 1'b1;
      end else if (handshake) begin
        key_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_safe_keypad_scanner.sv
// Bench for safe_keypad_scanner: keypad matrix model, handshake monitor,
// a table of single-key presses, hand-written corner sequences and a
// randomized press/door run checked against a simple event-list model.
module tb_safe_keypad_scanner;

  localparam int RS = 2;
  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] row_no;
  logic [2:0] col_n;
  logic       door;
  logic       kv;
  logic [3:0] kc;
  logic       kr;
  logic       ovr;
  logic [2:0] pressed [4];

  always #5 clk = ~clk;

  safe_keypad_scanner #(.ROW_SETTLE(RS), .DEBOUNCE_CYCLES(DC)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .row_no       (row_no),
    .col_ni       (col_n),
    .door_sealed_i(door),
    .key_valid_o  (kv),
    .key_code_o   (kc),
    .key_ready_i  (kr),
    .overrun_o    (ovr)
  );

  // Matrix: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col_n = 3'b111;
    for (int r = 0; r < 4; r++)
      if (!row_no[r]) col_n = col_n & ~pressed[r];
  end

  // Handshake / overrun monitor, sampled away from the active edge.
  logic [3:0] ev_q [$];
  int ovr_cnt = 0;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (kv && kr) ev_q.push_back(kc);
      if (ovr) ovr_cnt++;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run(input int n, input bit rnd_ready);
    repeat (n) begin
      if (rnd_ready) kr = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
  endtask

  // Reference legend: digits 1..9 fill rows 0..2 left to right; bottom row is CLEAR, 0, OK.
  function automatic logic [3:0] ref_code(input int r, input int c);
    if (r == 3) return (c == 0) ? 4'hA : (c == 1) ? 4'h0 : 4'hB;
    return 4'(r * 3 + c + 1);
  endfunction

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] c;
    logic [3:0] code;
  } vec_t;

  vec_t       tbl [12];
  logic [3:0] exp_q [$];
  int         o0;
  int         rr, cc, k;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before timeout");
    $fatal(1);
  end

  initial begin
    for (int r = 0; r < 4; r++) pressed[r] = 3'b000;
    rst_n = 1'b0;
    door  = 1'b0;
    kr    = 1'b1;
    #1;
    check("reset_row", row_no, 4'b1110);
    check("reset_valid", kv, 1'b0);
    check("reset_code", kc, 4'h0);
    check("reset_overrun", ovr, 1'b0);
    run(3, 0);
    rst_n = 1'b1;
    run(2, 0);

    // Every key once, generous hold and release.
    tbl[0]  = '{2'd0, 2'd0, 4'h1};
    tbl[1]  = '{2'd0, 2'd1, 4'h2};
    tbl[2]  = '{2'd0, 2'd2, 4'h3};
    tbl[3]  = '{2'd1, 2'd0, 4'h4};
    tbl[4]  = '{2'd1, 2'd1, 4'h5};
    tbl[5]  = '{2'd1, 2'd2, 4'h6};
    tbl[6]  = '{2'd2, 2'd0, 4'h7};
    tbl[7]  = '{2'd2, 2'd1, 4'h8};
    tbl[8]  = '{2'd2, 2'd2, 4'h9};
    tbl[9]  = '{2'd3, 2'd0, 4'hA};
    tbl[10] = '{2'd3, 2'd1, 4'h0};
    tbl[11] = '{2'd3, 2'd2, 4'hB};
    for (int i = 0; i < 12; i++) begin
      ev_q.delete();
      pressed[tbl[i].r][tbl[i].c] = 1'b1;
      run(60, 0);
      pressed[tbl[i].r][tbl[i].c] = 1'b0;
      run(30, 0);
      check($sformatf("tbl%0d_count", i), ev_q.size(), 1);
      if (ev_q.size() > 0) check($sformatf("tbl%0d_code", i), ev_q[0], tbl[i].code);
    end

    // Long hold of '5': one event only.
    ev_q.delete(); o0 = ovr_cnt;
    pressed[1][1] = 1'b1;
    run(100, 0);
    pressed[1][1] = 1'b0;
    run(30, 0);
    check("hold5_count", ev_q.size(), 1);
    if (ev_q.size() > 0) check("hold5_code", ev_q[0], 4'h5);
    check("hold5_overrun", ovr_cnt - o0, 0);
    check("hold5_valid_low", kv, 1'b0);

    // '#' with bouncy press and bouncy release.
    ev_q.delete(); o0 = ovr_cnt;
    pressed[3][2] = 1'b1; run(1, 0);
    pressed[3][2] = 1'b0; run(2, 0);
    pressed[3][2] = 1'b1; run(2, 0);
    pressed[3][2] = 1'b0; run(1, 0);
    pressed[3][2] = 1'b1; run(60, 0);
    pressed[3][2] = 1'b0; run(2, 0);
    pressed[3][2] = 1'b1; run(1, 0);
    pressed[3][2] = 1'b0; run(2, 0);
    pressed[3][2] = 1'b1; run(1, 0);
    pressed[3][2] = 1'b0; run(40, 0);
    check("bounce_count", ev_q.size(), 1);
    if (ev_q.size() > 0) check("bounce_code", ev_q[0], 4'hB);
    check("bounce_overrun", ovr_cnt - o0, 0);

    // Consumer stalled: '1' held in register, '9' dropped with overrun.
    ev_q.delete(); o0 = ovr_cnt;
    kr = 1'b0;
    pressed[0][0] = 1'b1; run(40, 0);
    pressed[0][0] = 1'b0; run(30, 0);
    pressed[2][2] = 1'b1; run(40, 0);
    pressed[2][2] = 1'b0; run(30, 0);
    check("stall_valid", kv, 1'b1);
    check("stall_code", kc, 4'h1);
    check("stall_overrun", ovr_cnt - o0, 1);
    check("stall_no_handshake", ev_q.size(), 0);
    kr = 1'b1;
    run(1, 0);
    check("stall_valid_falls", kv, 1'b0);
    check("stall_code_holds", kc, 4'h1);
    check("stall_drain_count", ev_q.size(), 1);
    if (ev_q.size() > 0) check("stall_drain_code", ev_q[0], 4'h1);

    // Door seal with leading glitch, then unseal.
    ev_q.delete(); o0 = ovr_cnt;
    door = 1'b1; run(2, 0);
    door = 1'b0; run(6, 0);
    door = 1'b1; run(30, 0);
    check("door_seal_count", ev_q.size(), 1);
    if (ev_q.size() > 0) check("door_seal_code", ev_q[0], 4'hC);
    door = 1'b0; run(30, 0);
    check("door_unseal_count", ev_q.size(), 1);
    check("door_overrun", ovr_cnt - o0, 0);

    // '4' and '6' together: ghost pattern ignored until '6' lets go.
    ev_q.delete();
    pressed[1][0] = 1'b1;
    pressed[1][2] = 1'b1;
    run(100, 0);
    check("dual_none", ev_q.size(), 0);
    pressed[1][2] = 1'b0;
    run(60, 0);
    check("dual_then4_count", ev_q.size(), 1);
    if (ev_q.size() > 0) check("dual_then4_code", ev_q[0], 4'h4);
    pressed[1][0] = 1'b0;
    run(30, 0);
    check("dual_release_count", ev_q.size(), 1);

    // Reset while debouncing a row-1 key.
    pressed[1][1] = 1'b1;
    k = 0;
    while (row_no !== 4'b1101 && k < 50) begin
      run(1, 0);
      k++;
    end
    check("rst_deb_row1_reached", row_no, 4'b1101);
    run(4, 0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_deb_row", row_no, 4'b1110);
    check("rst_deb_valid", kv, 1'b0);
    check("rst_deb_overrun", ovr, 1'b0);
    pressed[1][1] = 1'b0;
    run(3, 0);
    rst_n = 1'b1;
    run(1, 0);
    check("rst_deb_restart_row", row_no, 4'b1110);
    run(20, 0);

    // Reset while an event is pending: event lost.
    kr = 1'b0;
    pressed[2][0] = 1'b1; run(40, 0);
    pressed[2][0] = 1'b0; run(30, 0);
    check("rst_pend_valid_before", kv, 1'b1);
    check("rst_pend_code_before", kc, 4'h7);
    ev_q.delete();
    #2 rst_n = 1'b0;
    #1;
    check("rst_pend_valid", kv, 1'b0);
    check("rst_pend_code", kc, 4'h0);
    check("rst_pend_row", row_no, 4'b1110);
    run(3, 0);
    rst_n = 1'b1;
    kr = 1'b1;
    run(10, 0);
    check("rst_pend_lost", ev_q.size(), 0);

    // Randomized presses and door changes, random consumer readiness.
    ev_q.delete(); exp_q.delete(); o0 = ovr_cnt;
    for (int i = 0; i < 16; i++) begin
      rr = $urandom_range(0, 3);
      cc = $urandom_range(0, 2);
      exp_q.push_back(ref_code(rr, cc));
      pressed[rr][cc] = 1'b1;
      run($urandom_range(45, 70), 1);
      pressed[rr][cc] = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        door = ~door;
        if (door) exp_q.push_back(4'hC);
      end
      run($urandom_range(30, 50), 1);
    end
    kr = 1'b1;
    run(10, 0);
    check("rand_count", ev_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < ev_q.size()) check($sformatf("rand_ev%0d", i), ev_q[i], exp_q[i]);
    check("rand_overrun", ovr_cnt - o0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/safe_keypad_scanner.md
Name: safe_keypad_scanner

Overview:
- Upstream input stage of the safe controller: scans a 4x3 matrix keypad, debounces presses and the door-seal sensor, and emits one 4-bit key event per press in the safe key encoding.
- Codes: KEY_0..KEY_9 = 0x0..0x9, KEY_CLEAR = 0xA, KEY_OK = 0xB, DOOR_SEALED = 0xC.
- Events leave through a valid/ready handshake to the safe FSM.

Parameters:
- ROW_SETTLE, 4, cycles each row is driven before columns are sampled (>=2).
- DEBOUNCE_CYCLES, 16, consecutive identical samples required to accept a press, release or door edge (>=2).

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- row_no  out  4  row drive, active-low, one-hot-zero while scanning
- col_ni  in  3  column sense, active-low (pulled up), asynchronous
- door_sealed_i  in  1  door seal sensor, 1 = sealed, asynchronous
- key_valid_o  out  1  event pending
- key_code_o  out  4  event code, stable while key_valid_o=1
- key_ready_i  in  1  consumer accepts event when key_valid_o & key_ready_i
- overrun_o  out  1  one-cycle pulse: event dropped because output register occupied

Behaviour:
- Reset values: row_no=4'b1110 (row 0 driven), key_valid_o=0, key_code_o=0x0, overrun_o=0, FSM=SCAN, all counters 0, door synchroniser and debounced level = 0.
- col_ni and door_sealed_i each pass through a 2-flop synchroniser; all logic uses synchronised values.
- Key map (row, col -> code):
  - row0: 1, 2, 3
  - row1: 4, 5, 6
  - row2: 7, 8, 9
  - row3: CLEAR, 0, OK
- FSM:
  - SCAN: drive current row low. After ROW_SETTLE cycles, sample columns.
    - Exactly one column low: latch row/col, clear debounce count, go DEBOUNCE.
    - Zero or more than one column low: advance row (3 wraps to 0), restart settle count.
  - DEBOUNCE: hold row. Count while the sampled column pattern equals the latched one.
    - Mismatch: back to SCAN, same row, settle count restarted.
    - Count reaches DEBOUNCE_CYCLES: go PRESSED.
  - PRESSED: produce the event for one cycle, then go RELEASE.
  - RELEASE: hold row. Count cycles with all columns high; any low column resets the count.
    - Count reaches DEBOUNCE_CYCLES: go SCAN on the next row.
  - Holding a key produces exactly one event. A second key pressed during RELEASE is ignored until full release.
- Door: debounced level changes only after DEBOUNCE_CYCLES consecutive synchronised samples differ from it. A 0->1 debounced transition produces a DOOR_SEALED event; 1->0 produces none.
- Event register:
  - Event and (key_valid_o=0 or handshake this cycle): load code, key_valid_o=1 next cycle.
  - Handshake with no new event: key_valid_o=0 next cycle.
  - Event while key_valid_o=1 and no handshake: event dropped, overrun_o=1 for one cycle, register unchanged.
  - Key event and door event in the same cycle: door event wins; key event counts as dropped (overrun_o=1).
- key_code_o holds its last value after key_valid_o falls.
- Latency:
  - col_ni falling to key_valid_o rising, with the key's row driven and the settle window just ending: 2 (sync) + 1 (SCAN sample) + DEBOUNCE_CYCLES + 1 (PRESSED) + 1 (register) cycles.
  - Worst case adds up to 4*ROW_SETTLE scan cycles.
- Reset asserted mid-operation: immediate return to reset values. A pending event is lost.

Test Plan:
- ROW_SETTLE=2, DEBOUNCE_CYCLES=4; key '5' (row1, col1) held 100 cycles, key_ready_i=1 -> exactly one key_valid_o pulse with code 0x5, no overrun_o.
- Press '#' (row3, col2) with 3 bounce toggles of 1-2 cycles each, then stable -> single event code 0xB; release with bounces -> no extra event.
- key_ready_i=0; press '1', release, press '9' -> key_valid_o=1, code 0x1 held; one overrun_o pulse on the '9' event; raise key_ready_i -> key_valid_o falls next cycle.
- door_sealed_i 0->1 with a 2-cycle glitch first, then stable -> one event code 0xC; 1->0 -> no event.
- Keys '4' and '6' (row1, cols 0 and 2) held together -> no event. Release '6' with '4' still held -> event 0x4.
- rst_ni asserted while in DEBOUNCE and while key_valid_o=1 -> all outputs at reset values in the same cycle; after release, scanning restarts at row 0 (row_no=4'b1110).
